// File: rtl/endian_copy_ctrl.sv
// Copy engine: moves a packet of 32-bit words from InBuf to OutBuf, reversing byte order.
// Optional build macro COPY_CHECKSUM_EN adds oChkSum, a running sum of the written words.
module endian_copy_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int MAX_WD = 512
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStDtCp,
    input  logic [9:0]        iPktWdSize,
    output logic              oBusy,
    output logic              oDtCpDone,
    output logic              oRdEn_InBuf,
    output logic [ADDR_W-1:0] oRdAddr_InBuf,
    input  logic [DATA_W-1:0] iRdDt_InBuf,
    output logic              oWrEn_OutBuf,
    output logic [ADDR_W-1:0] oWrAddr_OutBuf,
    output logic [DATA_W-1:0] oWrDt_OutBuf
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [31:0]       oChkSum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [9:0] MaxWdC = 10'(MAX_WD);

    state_t     rState;
    state_t     nxtState;
    logic [9:0] rSize;
    logic [9:0] nxtSize;
    logic [9:0] rRdCnt;
    logic [9:0] nxtRdCnt;
    logic       startAcc;

    function automatic logic [DATA_W-1:0] byteSwap(input logic [DATA_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Next-state, size latch and read-counter logic
    always_comb begin
        nxtState = rState;
        nxtSize  = rSize;
        nxtRdCnt = rRdCnt;
        startAcc = 1'b0;
        case (rState)
            IDLE: begin
                if (iStDtCp) begin
                    startAcc = 1'b1;
                    nxtSize  = (iPktWdSize > MaxWdC) ? MaxWdC : iPktWdSize;
                    nxtRdCnt = 10'd0;
                    if (nxtSize == 10'd0) begin
                        nxtState = DONE;
                    end else begin
                        nxtState = RD;
                    end
                end else begin
                    nxtState = IDLE;
                end
            end
            RD: begin
                nxtRdCnt = rRdCnt + 10'd1;
                if (rRdCnt == rSize - 10'd1) begin
                    nxtState = DRAIN;
                end else begin
                    nxtState = RD;
                end
            end
            DRAIN:   nxtState = DONE;
            DONE:    nxtState = IDLE;
            default: nxtState = IDLE;
        endcase
    end

    // State register and registered outputs; write side trails the read side by one cycle
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rState         <= IDLE;
            rSize          <= 10'd0;
            rRdCnt         <= 10'd0;
            oBusy          <= 1'b0;
            oDtCpDone      <= 1'b0;
            oRdEn_InBuf    <= 1'b0;
            oRdAddr_InBuf  <= {ADDR_W{1'b0}};
            oWrEn_OutBuf   <= 1'b0;
            oWrAddr_OutBuf <= {ADDR_W{1'b0}};
        end else begin
            rState         <= nxtState;
            rSize          <= nxtSize;
            rRdCnt         <= nxtRdCnt;
            oBusy          <= (nxtState != IDLE);
            oDtCpDone      <= (nxtState == DONE);
            oRdEn_InBuf    <= (nxtState == RD);
            oRdAddr_InBuf  <= (nxtState == RD) ? nxtRdCnt[ADDR_W-1:0] : {ADDR_W{1'b0}};
            oWrEn_OutBuf   <= oRdEn_InBuf;
            oWrAddr_OutBuf <= oRdAddr_InBuf;
        end
    end

    // Write data is gated so the bus stays at zero whenever no write is issued
    assign oWrDt_OutBuf = oWrEn_OutBuf ? byteSwap(iRdDt_InBuf) : {DATA_W{1'b0}};

`ifdef COPY_CHECKSUM_EN
    // Running checksum of written words, cleared on an accepted start
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oChkSum <= 32'd0;
        end else if (startAcc) begin
            oChkSum <= 32'd0;
        end else if (oWrEn_OutBuf) begin
            oChkSum <= oChkSum + oWrDt_OutBuf;
        end else begin
            oChkSum <= oChkSum;
        end
    end
`endif

endmodule

// File: tb/tb_endian_copy_ctrl.sv
// Directed bench for endian_copy_ctrl with an InBuf read model and OutBuf capture.
module tb_endian_copy_ctrl;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStDtCp;
    logic [9:0]  iPktWdSize;
    logic        oBusy;
    logic        oDtCpDone;
    logic        oRdEn_InBuf;
    logic [8:0]  oRdAddr_InBuf;
    logic [31:0] rdDt;
    logic        oWrEn_OutBuf;
    logic [8:0]  oWrAddr_OutBuf;
    logic [31:0] oWrDt_OutBuf;
`ifdef COPY_CHECKSUM_EN
    logic [31:0] oChkSum;
`endif

    logic [31:0] inBuf  [0:511];
    logic [31:0] outBuf [0:511];
    int nChecks = 0;
    int nErrs   = 0;

    endian_copy_ctrl dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iStDtCp        (iStDtCp),
        .iPktWdSize     (iPktWdSize),
        .oBusy          (oBusy),
        .oDtCpDone      (oDtCpDone),
        .oRdEn_InBuf    (oRdEn_InBuf),
        .oRdAddr_InBuf  (oRdAddr_InBuf),
        .iRdDt_InBuf    (rdDt),
        .oWrEn_OutBuf   (oWrEn_OutBuf),
        .oWrAddr_OutBuf (oWrAddr_OutBuf),
        .oWrDt_OutBuf   (oWrDt_OutBuf)
`ifdef COPY_CHECKSUM_EN
        ,
        .oChkSum        (oChkSum)
`endif
    );

    always #5 iClk = ~iClk;

    // InBuf synchronous read and OutBuf write capture
    always @(posedge iClk) begin
        if (oRdEn_InBuf) rdDt <= inBuf[oRdAddr_InBuf];
        if (oWrEn_OutBuf) outBuf[oWrAddr_OutBuf] <= oWrDt_OutBuf;
    end

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrs++;
            $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkIdleOutputs(input string tag, input int cyc);
        chk({tag, ".busy"},   cyc, 32'(oBusy),          32'd0);
        chk({tag, ".done"},   cyc, 32'(oDtCpDone),      32'd0);
        chk({tag, ".rdEn"},   cyc, 32'(oRdEn_InBuf),    32'd0);
        chk({tag, ".rdAddr"}, cyc, 32'(oRdAddr_InBuf),  32'd0);
        chk({tag, ".wrEn"},   cyc, 32'(oWrEn_OutBuf),   32'd0);
        chk({tag, ".wrAddr"}, cyc, 32'(oWrAddr_OutBuf), 32'd0);
        chk({tag, ".wrDt"},   cyc, oWrDt_OutBuf,        32'd0);
    endtask

    // Start a copy of 'size' (nEff after clamp); optionally pulse a second start in cycle injC
    task automatic runCopy(input string tag, input int size, input int nEff, input int injC, input int injSize);
        int doneC;
        doneC = (nEff == 0) ? 1 : nEff + 2;
        @(negedge iClk);
        iStDtCp    = 1'b1;
        iPktWdSize = 10'(size);
        @(negedge iClk);
        for (int c = 1; c <= doneC + 1; c++) begin
            iStDtCp = (c == injC);
            if (c == injC) iPktWdSize = 10'(injSize);
            chk({tag, ".busy"}, c, 32'(oBusy),        32'(c <= doneC));
            chk({tag, ".done"}, c, 32'(oDtCpDone),    32'(c == doneC));
            chk({tag, ".rdEn"}, c, 32'(oRdEn_InBuf),  32'(c >= 1 && c <= nEff));
            chk({tag, ".wrEn"}, c, 32'(oWrEn_OutBuf), 32'(c >= 2 && c <= nEff + 1));
            if (c <= nEff) chk({tag, ".rdAddr"}, c, 32'(oRdAddr_InBuf), 32'(c - 1));
            if (c >= 2 && c <= nEff + 1) chk({tag, ".wrAddr"}, c, 32'(oWrAddr_OutBuf), 32'(c - 2));
            @(negedge iClk);
        end
        iStDtCp = 1'b0;
    endtask

    initial begin
        iRst       = 1'b1;
        iStDtCp    = 1'b0;
        iPktWdSize = 10'd0;
        repeat (3) @(negedge iClk);
        chkIdleOutputs("reset", 0);
        iRst = 1'b0;

        // 1: basic 4-word copy; a start during DONE (cycle 6) must be ignored
        inBuf[0] = 32'h11223344;
        inBuf[1] = 32'hAABBCCDD;
        inBuf[2] = 32'h00000001;
        inBuf[3] = 32'hDEADBEEF;
        runCopy("t1", 4, 4, 6, 3);
        chk("t1.out0", 0, outBuf[0], 32'h44332211);
        chk("t1.out1", 0, outBuf[1], 32'hDDCCBBAA);
        chk("t1.out2", 0, outBuf[2], 32'h01000000);
        chk("t1.out3", 0, outBuf[3], 32'hEFBEADDE);

        // 2: zero-size packet, done in cycle 1 with no buffer access
        runCopy("t2", 0, 0, 0, 0);

        // 3: oversize request clamped to 512 words, addresses 0..511
        for (int i = 0; i < 512; i++) inBuf[i] = {8'(i), 8'hC3, 8'(i >> 8), 8'h5A};
        runCopy("t3", 1023, 512, 0, 0);
        for (int i = 0; i < 512; i++) chk("t3.out", i, outBuf[i], {8'h5A, 8'(i >> 8), 8'hC3, 8'(i)});

        // 4: second start while busy ignored, then a fresh start accepted
        for (int i = 0; i < 8; i++) inBuf[i] = 32'h10000000 + 32'(i);
        runCopy("t4", 8, 8, 3, 2);
        for (int i = 0; i < 8; i++) chk("t4.out", i, outBuf[i], {8'(i), 8'h00, 8'h00, 8'h10});
        inBuf[0] = 32'hCAFEF00D;
        runCopy("t4b", 1, 1, 0, 0);
        chk("t4b.out0", 0, outBuf[0], 32'h0DF0FECA);

        // 5: reset in the middle of a 16-word copy abandons it
        @(negedge iClk);
        iStDtCp    = 1'b1;
        iPktWdSize = 10'd16;
        @(negedge iClk);
        iStDtCp = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk("t5.busy", c, 32'(oBusy),     32'd1);
            chk("t5.done", c, 32'(oDtCpDone), 32'd0);
            if (c < 7) @(negedge iClk);
        end
        iRst = 1'b1;
        @(negedge iClk);
        chkIdleOutputs("t5.rst", 8);
        iRst = 1'b0;
        for (int c = 9; c <= 12; c++) begin
            @(negedge iClk);
            chkIdleOutputs("t5.post", c);
        end
        inBuf[0] = 32'h01020304;
        runCopy("t5b", 1, 1, 0, 0);
        chk("t5b.out0", 0, outBuf[0], 32'h04030201);

`ifdef COPY_CHECKSUM_EN
        // 6: checksum over swapped words, cleared by the next start
        inBuf[0] = 32'h01000000;
        inBuf[1] = 32'h02000000;
        runCopy("t6", 2, 2, 0, 0);
        chk("t6.sum", 0, oChkSum, 32'h00000003);
        @(negedge iClk);
        chk("t6.hold", 0, oChkSum, 32'h00000003);
        iStDtCp    = 1'b1;
        iPktWdSize = 10'd0;
        @(negedge iClk);
        iStDtCp = 1'b0;
        chk("t6.clr", 1, oChkSum, 32'h00000000);
        repeat (2) @(negedge iClk);
`endif

        $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
        $finish;
    end

endmodule

// File: doc/endian_copy_ctrl.md
Name: endian_copy_ctrl

Overview:
Copy engine and sequencer that moves a packet from InBuf to OutBuf with 32-bit byte-order reversal.
- Started by the 1-clock start pulse and packet word size produced by the APB interface block.
- Issues word reads to InBuf (BufWrap, 1-cycle synchronous read) and byte-swapped writes to OutBuf.
- Returns a 1-clock done pulse that feeds the interrupt pending logic.

Parameters:
DATA_W, 32, data word width; fixed at 32 because the swap is byte-wise.
ADDR_W, 9, buffer word-address width.
MAX_WD, 512, largest legal packet size in words; larger requests are clamped to this value.

Ports:
iClk  input  1  rising-edge clock
iRst  input  1  reset: one clock; reset is synchronous and active-high
iStDtCp  input  1  start command, 1-clock pulse
iPktWdSize  input  10  packet size in 4-byte words, sampled on start
oBusy  output  1  copy in progress
oDtCpDone  output  1  1-clock done pulse
oRdEn_InBuf  output  1  InBuf read enable
oRdAddr_InBuf  output  ADDR_W  InBuf read word address
iRdDt_InBuf  input  DATA_W  InBuf read data, valid the cycle after oRdEn_InBuf
oWrEn_OutBuf  output  1  OutBuf write enable
oWrAddr_OutBuf  output  ADDR_W  OutBuf write word address
oWrDt_OutBuf  output  DATA_W  OutBuf write data (byte-swapped)

Behaviour:
Reset:
- While iRst=1, the state is IDLE and all outputs are 0, including oDtCpDone.
- Reset mid-copy abandons the transfer immediately. No done pulse is issued and the copy does not resume after reset.

FSM states: IDLE, RD, DRAIN, DONE.
- IDLE: on iStDtCp=1, latch rSize = min(iPktWdSize, MAX_WD).
  - If rSize=0, go to DONE.
  - Otherwise clear rRdCnt and go to RD.
- RD: oRdEn_InBuf=1, oRdAddr_InBuf=rRdCnt[ADDR_W-1:0], rRdCnt++ each cycle. When rRdCnt==rSize-1, go to DRAIN.
- DRAIN: one cycle with no read; the final write is issued. Then go to DONE.
- DONE: oDtCpDone=1 for exactly one cycle, then go to IDLE.

Read/write and address rules:
- All read outputs are registered.
- oWrEn_OutBuf and oWrAddr_OutBuf are registered copies of oRdEn_InBuf and oRdAddr_InBuf, delayed 1 cycle.
- oWrDt_OutBuf = {iRdDt[7:0], iRdDt[15:8], iRdDt[23:16], iRdDt[31:24]}, combinational from iRdDt_InBuf.
- OutBuf address k receives the swapped InBuf word k.
- rRdCnt is 10 bits. The address uses the low 9 bits, so word 511 is the last address and no wrap occurs within a legal packet.

Status and timing:
- oBusy=1 in RD, DRAIN and DONE; oBusy=0 in IDLE.
- Timing for size N≥1, with start sampled at edge E0:
  - reads occur in cycles 1..N;
  - writes occur in cycles 2..N+1;
  - oDtCpDone is high in cycle N+2;
  - oBusy is high in cycles 1..N+2.
- Size 0: oDtCpDone is high in cycle 1, with no buffer access.

Boundary cases:
- iStDtCp while oBusy=1 is ignored; rSize is not reloaded.
- iStDtCp in the same cycle as DONE is ignored. A new start is accepted from IDLE only, i.e. cycle N+3 at the earliest.
- iPktWdSize changing after the start edge has no effect on the transfer in progress.

Optional Feature:
Macro: COPY_CHECKSUM_EN
- Defined:
  - Adds output oChkSum [31:0], registered.
  - oChkSum clears to 0 on an accepted start and on reset.
  - On each cycle with oWrEn_OutBuf=1, it accumulates oChkSum += oWrDt_OutBuf, modulo 2^32.
  - It holds its value after done until the next start.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset with outputs checked, then size 4, InBuf[0..3]={0x11223344, 0xAABBCCDD, 0x00000001, 0xDEADBEEF}, start → OutBuf[0..3]={0x44332211, 0xDDCCBBAA, 0x01000000, 0xEFBEADDE}; done pulse exactly at cycle 6; oBusy high in cycles 1..6.
2. Size 0 start → oDtCpDone=1 in cycle 1; no oRdEn/oWrEn ever asserted; oBusy high only in cycle 1.
3. Size 0x3FF (1023) start → clamped to 512 writes with addresses 0..511, no wrap to 0; done at cycle 514.
4. Size 8, second iStDtCp at cycle 3 with size 2 → ignored: 8 writes, a single done at cycle 10; a new start at cycle 11 is accepted.
5. Size 16, iRst=1 at cycle 7 → all outputs 0 the next cycle; no done pulse; fresh start of size 1 after reset completes normally with done at cycle 3.
6. COPY_CHECKSUM_EN build, size 2, InBuf={0x01000000, 0x02000000} → oChkSum=0x00000003 after done; a subsequent start clears it to 0.
